// File: rtl/alu_nbits_serial.sv
// Slice-serial integer ALU: a WIDTH-bit operation runs SLICE bits per clock,
// LSB slice first, with a valid/ready handshake on both sides and status flags.
module alu_nbits_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    OP_AND = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010, OP_SUB  = 3'b011,
    OP_XOR = 3'b100, OP_NOR = 3'b101, OP_SLT = 3'b110, OP_PASS = 3'b111
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_t              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;
  logic [WIDTH-1:0] r_result;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_carry;
  logic             r_overflow;
  logic             r_zero;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE:0]   w_sum;
  logic             w_ovf;
  logic             w_last;
  logic             w_is_sub;
  logic [SLICE-1:0] w_res_sl;
  logic [WIDTH-1:0] w_res_full;

  // SUB and SLT share the adder: B is stored inverted and the chain starts at 1.
  assign w_is_sub = (op_t'(op) == OP_SUB) || (op_t'(op) == OP_SLT);

  assign w_a_sl = r_a[int'(r_cnt) * SLICE +: SLICE];
  assign w_b_sl = r_b[int'(r_cnt) * SLICE +: SLICE];
  assign w_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_c};
  // Carry into the MSB is recovered from the MSB's own sum bit.
  assign w_ovf  = (w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_sum[SLICE-1]) ^ w_sum[SLICE];
  assign w_last = (r_cnt == CNT_W'(N - 1));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_res_sl = '0;
    case (r_op)
      OP_AND:  w_res_sl = w_a_sl & w_b_sl;
      OP_OR:   w_res_sl = w_a_sl | w_b_sl;
      OP_XOR:  w_res_sl = w_a_sl ^ w_b_sl;
      OP_NOR:  w_res_sl = ~(w_a_sl | w_b_sl);
      OP_PASS: w_res_sl = w_a_sl;
      default: w_res_sl = w_sum[SLICE-1:0];
    endcase
    w_res_full = r_result;
    w_res_full[int'(r_cnt) * SLICE +: SLICE] = w_res_sl;
    if (r_op == OP_SLT)
      w_res_full = {{(WIDTH-1){1'b0}}, w_sum[SLICE-1] ^ w_ovf};
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and also aborts a running op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_AND;
      r_cnt       <= '0;
      r_c         <= 1'b0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= w_is_sub ? ~b : b;
            r_op       <= op_t'(op);
            r_c        <= w_is_sub;
            r_cnt      <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_c      <= w_sum[SLICE];
          r_result <= w_res_full;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_carry     <= (r_op == OP_ADD || r_op == OP_SUB) ? w_sum[SLICE] : 1'b0;
            r_overflow  <= (r_op == OP_ADD || r_op == OP_SUB) ? w_ovf : 1'b0;
            r_zero      <= (w_res_full == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_nbits_serial.sv
// Bench for alu_nbits_serial: a 32/8 instance driven with directed and random ops
// against an arithmetic reference model, plus a 16/16 single-slice instance.
module tb_alu_nbits_serial;

  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready, carry, overflow, zero;
  logic [W-1:0] a, b, result;
  logic [2:0]   op;

  logic         rst16, in_valid16, in_ready16, out_valid16, out_ready16;
  logic         carry16, overflow16, zero16;
  logic [15:0]  a16, b16, result16;
  logic [2:0]   op16;

  int n_checks = 0;
  int n_errors = 0;

  alu_nbits_serial #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero)
  );

  alu_nbits_serial #(.WIDTH(16), .SLICE(16)) u_dut16 (
    .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .carry(carry16), .overflow(overflow16), .zero(zero16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {zero, overflow, carry, result} from plain two's-complement arithmetic.
  function automatic logic [34:0] model(input logic [2:0] mop, input logic [31:0] ma, mb);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (mop)
      3'd0: r = ma & mb;
      3'd1: r = ma | mb;
      3'd2: begin
        s = {1'b0, ma} + {1'b0, mb};
        r = s[31:0];
        c = s[32];
        v = (ma[31] == mb[31]) && (r[31] != ma[31]);
      end
      3'd3: begin
        r = ma - mb;
        c = (ma >= mb);
        v = (ma[31] != mb[31]) && (r[31] != ma[31]);
      end
      3'd4: r = ma ^ mb;
      3'd5: r = ~(ma | mb);
      3'd6: r = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
      default: r = ma;
    endcase
    return {(r == 32'd0), v, c, r};
  endfunction

  // Issues one op from a negedge and completes the output handshake.
  task automatic run_op(input logic [2:0] op_i, input logic [31:0] a_i, b_i,
                        input int hold, input bit b2b, input bit scramble,
                        output logic [31:0] r_o, output logic c_o, v_o, z_o);
    logic [34:0] exp;
    string       tag;
    int          t;
    exp = model(op_i, a_i, b_i);
    tag = $sformatf("op%0d a=%h b=%h", op_i, a_i, b_i);
    t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    check({tag, " in_ready"}, in_ready, 1);
    op = op_i; a = a_i; b = b_i; in_valid = 1'b1; out_ready = b2b;
    @(negedge clk);
    in_valid = 1'b0;
    if (scramble) begin a = $urandom; b = $urandom; op = 3'($urandom); end
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    check({tag, " latency"}, t, N);
    check({tag, " result"}, result, exp[31:0]);
    check({tag, " flags"}, {zero, overflow, carry}, exp[34:32]);
    r_o = result; c_o = carry; v_o = overflow; z_o = zero;
    if (b2b) begin
      @(negedge clk);
      check({tag, " b2b pulse"}, out_valid, 0);
      out_ready = 1'b0;
    end else begin
      repeat (hold) begin
        @(negedge clk);
        check({tag, " hold"}, {in_ready, out_valid, zero, overflow, carry, result},
              {2'b01, exp[34:32], exp[31:0]});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " drop"}, out_valid, 0);
    end
  endtask

  logic [31:0] r;
  logic        c, v, z;
  bit          seen;
  logic [31:0] corners [6] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1, 32'hFF};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    rst16 = 1'b1; in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst16 = 1'b0;
    check("reset", {in_ready, out_valid, result, carry, overflow, zero}, {2'b10, 32'h0, 3'b000});

    run_op(3'd2, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, r, c, v, z);
    check("add wrap", {r, c, v, z}, {32'h0, 3'b101});
    run_op(3'd2, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, r, c, v, z);
    check("add ovf", {r, c, v, z}, {32'h8000_0000, 3'b010});
    run_op(3'd3, 32'd5, 32'd7, 0, 0, 0, r, c, v, z);
    check("sub borrow", {r, c}, {32'hFFFF_FFFE, 1'b0});
    run_op(3'd6, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, r, c, v, z);
    check("slt -1<1", {r, c, v, z}, {32'h1, 3'b000});
    run_op(3'd6, 32'h8000_0000, 32'h1, 0, 0, 0, r, c, v, z);
    check("slt ovf", r, 32'h1);
    run_op(3'd0, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 0, 0, 0, r, c, v, z);
    check("and", r, 32'h00F0_A5A5);
    run_op(3'd1, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 0, 0, 0, r, c, v, z);
    check("or", r, 32'hFFF0_FFFF);
    run_op(3'd4, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 0, 0, 0, r, c, v, z);
    check("xor", r, 32'hFF00_5A5A);
    run_op(3'd5, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 0, 0, 0, r, c, v, z);
    check("nor", r, 32'h000F_0000);
    run_op(3'd7, 32'hF0F0_A5A5, 32'h0FF0_FFFF, 5, 0, 1, r, c, v, z);
    check("pass hold+scramble", r, 32'hF0F0_A5A5);
    run_op(3'd3, 32'h1234_5678, 32'h1234_5678, 0, 1, 1, r, c, v, z);
    check("sub equal b2b", {r, c, z}, {32'h0, 2'b11});

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      run_op(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 2),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), r, c, v, z);
    end

    // Abort in the second RUN cycle.
    op = 3'd2; a = 32'h1; b = 32'h1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort idle", {in_ready, out_valid, result}, {2'b10, 32'h0});
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    check("abort no valid", seen, 0);
    run_op(3'd2, 32'd40, 32'd2, 0, 0, 0, r, c, v, z);
    check("after abort", r, 32'd42);

    // Single-slice instance.
    check("n1 reset", {in_ready16, out_valid16, result16}, {2'b10, 16'h0});
    op16 = 3'd2; a16 = 16'h8000; b16 = 16'h8000; in_valid16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    begin
      int t;
      t = 0;
      while (!out_valid16 && t < 10) begin @(negedge clk); t++; end
      check("n1 latency", t, 1);
    end
    check("n1 add", {result16, carry16, overflow16, zero16}, {16'h0, 3'b111});
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
    check("n1 drop", {in_ready16, out_valid16}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
